// File: rtl/panel_keypad_sequencer.sv
// panel_keypad_sequencer: front-panel keypad scanner, hex entry assembler and serialized command strober.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   kp_row       keypad rows, active-low
//   kp_col       keypad column drive, one bit low at a time
//   func_btn     raw active-high function buttons
//   entry        assembled 16-bit hex entry
//   entry_valid  high while digit_count != 0
//   digit_count  digits entered, saturating at 4
//   cmd_pulse    one-hot single-cycle command strobes (0 step .. 11 toPC)
//   Optional feature macro: PANEL_AUTOREPEAT_EN (auto-repeat of dec and storeinc)
module panel_keypad_sequencer #(
    parameter int SCAN_DIV       = 5000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_FRAMES  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  kp_row,
    output logic [3:0]  kp_col,
    input  logic [11:0] func_btn,
    output logic [15:0] entry,
    output logic        entry_valid,
    output logic [2:0]  digit_count,
    output logic [11:0] cmd_pulse
);
    localparam int VW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [VW-1:0] DIV_LAST = VW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_N     = DW'(DEBOUNCE_SCANS);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_SCANS - 1);
    // storeinc, load, toA..toPC consume the entry
    localparam logic [11:0] CONSUME    = 12'hFC8;

    if (SCAN_DIV < 1 || DEBOUNCE_SCANS < 1 || REPEAT_FRAMES < 1) begin : g_bad_params
        $error("panel_keypad_sequencer: parameters must be >= 1");
    end

    logic [VW-1:0] div;
    logic [1:0]    col;
    logic          sample, frame_end;
    logic [3:0]    act;
    logic          one_hot;
    logic [1:0]    row_idx;
    logic [1:0]    fr_keys, keys_n;
    logic [3:0]    fr_hex, hex_n;
    logic          key_down, key_acc;
    logic [DW-1:0] kcnt, kc_n;
    logic [3:0]    cand;
    logic [11:0]   sync1, sync2, btn_db, accept, rise, rep_fire, pending, low;
    logic [11:0][DW-1:0] bcnt;
    logic          clr;

    assign sample    = div == DIV_LAST;
    assign frame_end = sample && col == 2'd3;
    assign kp_col    = ~(4'b0001 << col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            col <= 2'd0;
        end else if (sample) begin
            div <= '0;
            col <= col + 2'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Per-frame classification: fr_keys 0 = NONE, 1 = single KEY, 2 = MULTI
    assign act     = ~kp_row;
    assign one_hot = act != 4'd0 && (act & (act - 4'd1)) == 4'd0;
    assign row_idx = act[0] ? 2'd0 : act[1] ? 2'd1 : act[2] ? 2'd2 : 2'd3;

    always_comb begin
        keys_n = (!sample || act == 4'd0) ? fr_keys : (one_hot && fr_keys == 2'd0) ? 2'd1 : 2'd2;
        hex_n  = (sample && one_hot && fr_keys == 2'd0) ? {col, row_idx} : fr_hex;
        kc_n   = (kcnt != '0 && hex_n == cand) ? kcnt + 1'b1 : DW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fr_keys <= 2'd0;
            fr_hex  <= 4'd0;
        end else begin
            fr_keys <= frame_end ? 2'd0 : keys_n;
            fr_hex  <= hex_n;
        end
    end

    // Key debounce; MULTI frames leave the counter and latched state untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_down <= 1'b0;
            key_acc  <= 1'b0;
            kcnt     <= '0;
            cand     <= 4'd0;
        end else begin
            key_acc <= 1'b0;
            if (frame_end) begin
                if (!key_down) begin
                    if (keys_n == 2'd1) begin
                        cand <= hex_n;
                        if (kc_n == DB_N) begin
                            key_down <= 1'b1;
                            key_acc  <= 1'b1;
                            kcnt     <= '0;
                        end else begin
                            kcnt <= kc_n;
                        end
                    end else if (keys_n == 2'd0) begin
                        kcnt <= '0;
                    end
                end else if (keys_n == 2'd0) begin
                    if (kcnt + 1'b1 == DB_N) begin
                        key_down <= 1'b0;
                        kcnt     <= '0;
                    end else begin
                        kcnt <= kcnt + 1'b1;
                    end
                end else if (keys_n == 2'd1) begin
                    kcnt <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 12; i++)
            accept[i] = frame_end && sync2[i] != btn_db[i] && bcnt[i] == DB_LAST;
        rise = accept & sync2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            btn_db <= '0;
            bcnt   <= '0;
        end else begin
            sync1 <= func_btn;
            sync2 <= sync1;
            for (int i = 0; i < 12; i++) begin
                if (frame_end) begin
                    if (accept[i]) begin
                        btn_db[i] <= sync2[i];
                        bcnt[i]   <= '0;
                    end else if (sync2[i] != btn_db[i]) begin
                        bcnt[i] <= bcnt[i] + 1'b1;
                    end else begin
                        bcnt[i] <= '0;
                    end
                end
            end
        end
    end

`ifdef PANEL_AUTOREPEAT_EN
    localparam int RW = $clog2(2 * REPEAT_FRAMES + 1);
    localparam logic [RW-1:0] REP_LAST   = RW'(2 * REPEAT_FRAMES - 1);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_FRAMES);
    logic [RW-1:0] rep3, rep5;

    // Repeats only while the raw button is still held, so a release in progress never fires
    assign rep_fire = {6'b0, frame_end && btn_db[5] && sync2[5] && rep5 == REP_LAST, 1'b0,
                       frame_end && btn_db[3] && sync2[3] && rep3 == REP_LAST, 3'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep3 <= '0;
            rep5 <= '0;
        end else begin
            rep3 <= !btn_db[3] ? '0 : frame_end ? (rep3 == REP_LAST ? REP_RELOAD : rep3 + 1'b1) : rep3;
            rep5 <= !btn_db[5] ? '0 : frame_end ? (rep5 == REP_LAST ? REP_RELOAD : rep5 + 1'b1) : rep5;
        end
    end
`else
    assign rep_fire = '0;
`endif

    // Lowest pending bit is issued each cycle; re-presses merge into a still-pending bit
    assign low = pending & (~pending + 12'd1);
    assign clr = |(cmd_pulse & CONSUME);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            cmd_pulse <= '0;
        end else begin
            pending   <= (pending & ~low) | rise | rep_fire;
            cmd_pulse <= low;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry       <= 16'h0000;
            digit_count <= 3'd0;
        end else if (key_acc) begin
            entry       <= {clr ? 12'h000 : entry[11:0], cand};
            digit_count <= clr ? 3'd1 : digit_count == 3'd4 ? 3'd4 : digit_count + 3'd1;
        end else if (clr) begin
            entry       <= 16'h0000;
            digit_count <= 3'd0;
        end
    end

    assign entry_valid = digit_count != 3'd0;
endmodule

// File: tb/tb_panel_keypad_sequencer.sv
// tb_panel_keypad_sequencer: directed self-checking bench for panel_keypad_sequencer.
module tb_panel_keypad_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  kp_row;
    logic [3:0]  kp_col;
    logic [11:0] func_btn = '0;
    logic [15:0] entry;
    logic        entry_valid;
    logic [2:0]  digit_count;
    logic [11:0] cmd_pulse;
    logic [15:0] keys = '0;
    int n_cmp = 0;
    int n_err = 0;

    panel_keypad_sequencer #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .REPEAT_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .kp_row(kp_row), .kp_col(kp_col), .func_btn(func_btn),
        .entry(entry), .entry_valid(entry_valid), .digit_count(digit_count), .cmd_pulse(cmd_pulse)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a held key pulls its row low while its column is driven low
    always_comb begin
        kp_row = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!kp_col[c])
                for (int r = 0; r < 4; r++)
                    if (keys[c * 4 + r]) kp_row[r] = 1'b0;
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] h);
        keys = '0;
        keys[h] = 1'b1;
        run(48);
        keys = '0;
        run(48);
    endtask

    task automatic align_frame();
        int t;
        logic [3:0] p;
        t = 0;
        p = kp_col;
        @(negedge clk);
        while (!(p == 4'b0111 && kp_col == 4'b1110) && t < 64) begin
            p = kp_col;
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 64) begin n_err++; $display("FAIL align_frame timeout got %0d cycles want < 64", t); end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        int idx;
        run(3);
        n_cmp++; if (kp_col !== 4'b1110) begin n_err++; $display("FAIL reset_kp_col got %b want 1110", kp_col); end
        n_cmp++; if (entry !== 16'h0) begin n_err++; $display("FAIL reset_entry got %h want 0000", entry); end
        n_cmp++; if (entry_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", entry_valid); end
        n_cmp++; if (digit_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", digit_count); end
        n_cmp++; if (cmd_pulse !== 12'h0) begin n_err++; $display("FAIL reset_cmd got %h want 000", cmd_pulse); end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            idx = (k / 4) % 4;
            exp_col = ~(4'b0001 << idx);
            n_cmp++;
            if (kp_col !== exp_col) begin n_err++; $display("FAIL scan_col[%0d] got %b want %b", k, kp_col, exp_col); end
        end
    endtask

    task automatic test_entry();
        key(4'h6);
        key(4'hA);
        n_cmp++; if (entry !== 16'h006A) begin n_err++; $display("FAIL entry_two got %h want 006a", entry); end
        n_cmp++; if (digit_count !== 3'd2) begin n_err++; $display("FAIL count_two got %0d want 2", digit_count); end
        n_cmp++; if (entry_valid !== 1'b1) begin n_err++; $display("FAIL valid_two got %b want 1", entry_valid); end
    endtask

    task automatic test_wrap_load();
        int t;
        int extra;
        for (int d = 1; d <= 5; d++) key(4'(d));
        n_cmp++; if (entry !== 16'h2345) begin n_err++; $display("FAIL entry_wrap got %h want 2345", entry); end
        n_cmp++; if (digit_count !== 3'd4) begin n_err++; $display("FAIL count_wrap got %0d want 4", digit_count); end
        func_btn[6] = 1'b1;
        t = 0;
        while (cmd_pulse == 12'h0 && t < 200) begin @(negedge clk); t++; end
        n_cmp++; if (cmd_pulse !== 12'h040) begin n_err++; $display("FAIL load_pulse got %h want 040", cmd_pulse); end
        n_cmp++; if (entry !== 16'h2345) begin n_err++; $display("FAIL load_entry_during got %h want 2345", entry); end
        n_cmp++; if (entry_valid !== 1'b1) begin n_err++; $display("FAIL load_valid_during got %b want 1", entry_valid); end
        @(negedge clk);
        n_cmp++; if (cmd_pulse !== 12'h0) begin n_err++; $display("FAIL load_pulse_width got %h want 000", cmd_pulse); end
        n_cmp++; if (entry !== 16'h0) begin n_err++; $display("FAIL load_clear got %h want 0000", entry); end
        n_cmp++; if (digit_count !== 3'd0) begin n_err++; $display("FAIL load_count got %0d want 0", digit_count); end
        extra = 0;
        for (int i = 0; i < 112; i++) begin
            if (i == 32) func_btn[6] = 1'b0;
            @(negedge clk);
            if (cmd_pulse != 12'h0) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL load_extra got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int t;
        int extra;
        key(4'h7);
        n_cmp++; if (entry !== 16'h0007) begin n_err++; $display("FAIL entry_seven got %h want 0007", entry); end
        func_btn = 12'h211;
        t = 0;
        while (cmd_pulse == 12'h0 && t < 200) begin @(negedge clk); t++; end
        n_cmp++; if (cmd_pulse !== 12'h001) begin n_err++; $display("FAIL b2b_step got %h want 001", cmd_pulse); end
        n_cmp++; if (entry !== 16'h0007) begin n_err++; $display("FAIL b2b_entry_step got %h want 0007", entry); end
        @(negedge clk);
        n_cmp++; if (cmd_pulse !== 12'h010) begin n_err++; $display("FAIL b2b_irq got %h want 010", cmd_pulse); end
        n_cmp++; if (entry !== 16'h0007) begin n_err++; $display("FAIL b2b_entry_irq got %h want 0007", entry); end
        @(negedge clk);
        n_cmp++; if (cmd_pulse !== 12'h200) begin n_err++; $display("FAIL b2b_tox got %h want 200", cmd_pulse); end
        n_cmp++; if (entry !== 16'h0007) begin n_err++; $display("FAIL b2b_entry_tox got %h want 0007", entry); end
        @(negedge clk);
        n_cmp++; if (cmd_pulse !== 12'h000) begin n_err++; $display("FAIL b2b_end got %h want 000", cmd_pulse); end
        n_cmp++; if (entry !== 16'h0000) begin n_err++; $display("FAIL b2b_clear got %h want 0000", entry); end
        extra = 0;
        for (int i = 0; i < 112; i++) begin
            if (i == 32) func_btn = '0;
            @(negedge clk);
            if (cmd_pulse != 12'h0) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL b2b_extra got %0d want 0", extra); end
    endtask

    task automatic test_glitch_multi();
        key(4'h9);
        n_cmp++; if (entry !== 16'h0009) begin n_err++; $display("FAIL entry_nine got %h want 0009", entry); end
        keys = 16'h0008;
        run(16);
        keys = '0;
        run(48);
        n_cmp++; if (entry !== 16'h0009) begin n_err++; $display("FAIL glitch_entry got %h want 0009", entry); end
        keys = 16'h0006;
        run(48);
        keys = '0;
        run(48);
        n_cmp++; if (entry !== 16'h0009) begin n_err++; $display("FAIL multi_entry got %h want 0009", entry); end
        n_cmp++; if (digit_count !== 3'd1) begin n_err++; $display("FAIL multi_count got %0d want 1", digit_count); end
    endtask

    task automatic test_reset_mid();
        int extra;
        align_frame();
        func_btn[0] = 1'b1;
        run(21);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (kp_col !== 4'b1110) begin n_err++; $display("FAIL rstmid_kp_col got %b want 1110", kp_col); end
        n_cmp++; if (entry !== 16'h0) begin n_err++; $display("FAIL rstmid_entry got %h want 0000", entry); end
        n_cmp++; if (entry_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", entry_valid); end
        n_cmp++; if (digit_count !== 3'd0) begin n_err++; $display("FAIL rstmid_count got %0d want 0", digit_count); end
        n_cmp++; if (cmd_pulse !== 12'h0) begin n_err++; $display("FAIL rstmid_cmd got %h want 000", cmd_pulse); end
        run(3);
        func_btn = '0;
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (cmd_pulse != 12'h0) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL rstmid_pulses got %0d want 0", extra); end
    endtask

    task automatic test_dec_hold();
        int pulses;
        int other;
        int want;
`ifdef PANEL_AUTOREPEAT_EN
        want = 4;
`else
        want = 1;
`endif
        align_frame();
        func_btn[5] = 1'b1;
        pulses = 0;
        other = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 160) func_btn[5] = 1'b0;
            @(negedge clk);
            if (cmd_pulse == 12'h020) pulses++;
            else if (cmd_pulse != 12'h0) other++;
        end
        n_cmp++; if (pulses !== want) begin n_err++; $display("FAIL dec_pulses got %0d want %0d", pulses, want); end
        n_cmp++; if (other !== 0) begin n_err++; $display("FAIL dec_other got %0d want 0", other); end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_wrap_load();
        test_back_to_back();
        test_glitch_multi();
        test_reset_mid();
        test_dec_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
